// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared types, response codes and width helper for axil_mstr
// Purpose : state enum, AXI response encodings, strobe-width helper.
// Ports   : none (package).
// Config  : AXIL_MSTR_TIMEOUT_EN adds the DRAIN state.
package axil_pkg;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RSP,
      RD_REQ,
      RD_RSP,
      RESP
`ifdef AXIL_MSTR_TIMEOUT_EN
      , DRAIN
`endif
   } state_t;

   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/axil_mstr_if.sv
// rtl/axil_mstr_if.sv - command/response and AXI4-Lite bundle for axil_mstr
// Purpose : groups the command/response handshake and the five AXI-Lite channels.
// Modports: master - the initiator (axil_mstr); slave - command source plus AXI responder.
interface axil_mstr_if
   import axil_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32
) ();
   localparam int pSTRB_WIDTH = strb_width(pDATA_WIDTH);

   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_write;
   logic [pADDR_WIDTH-1:0] cmd_addr;
   logic [pDATA_WIDTH-1:0] cmd_wdata;
   logic [pSTRB_WIDTH-1:0] cmd_wstrb;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [pDATA_WIDTH-1:0] rsp_rdata;
   logic [1:0]             rsp_resp;

   logic [pADDR_WIDTH-1:0] awaddr;
   logic                   awvalid;
   logic                   awready;
   logic [pDATA_WIDTH-1:0] wdata;
   logic [pSTRB_WIDTH-1:0] wstrb;
   logic                   wvalid;
   logic                   wready;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;
   logic [pADDR_WIDTH-1:0] araddr;
   logic                   arvalid;
   logic                   arready;
   logic [pDATA_WIDTH-1:0] rdata;
   logic [1:0]             rresp;
   logic                   rvalid;
   logic                   rready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axil_mstr_tmo.sv
// rtl/axil_mstr_tmo.sv - response-wait timeout counter for axil_mstr
// Purpose : counts cycles while en is high, cleared by clr; expire flags pTIMEOUT-1 reached.
// Ports   : clk, rst (sync active-high), clr, en in; expire out.
// Config  : instantiated only when AXIL_MSTR_TIMEOUT_EN is defined.
module axil_mstr_tmo #(
   parameter int pTIMEOUT = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int CW = $clog2(pTIMEOUT);

   logic [CW-1:0] cnt;

   // Saturates at the limit so a held expire never wraps back to zero.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && !expire) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = en && (cnt == CW'(pTIMEOUT - 1));

endmodule

// File: rtl/axil_mstr.sv
// rtl/axil_mstr.sv - single-outstanding command/response to AXI4-Lite initiator
// Purpose : turns one command at a time into an AXI-Lite read or write and returns
//           the response; all outputs come straight from flops.
// Ports   : ALCLK clock, ARESET sync active-high reset, bus (axil_mstr_if.master).
// Config  : AXIL_MSTR_TIMEOUT_EN enables the B/R wait timeout and the DRAIN state.
module axil_mstr
   import axil_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32
`ifdef AXIL_MSTR_TIMEOUT_EN
   , parameter int pTIMEOUT = 256
`endif
) (
   input  logic        ALCLK,
   input  logic        ARESET,
   axil_mstr_if.master bus
);
   localparam int pSTRB_WIDTH = strb_width(pDATA_WIDTH);

   state_t state, state_nxt;
   logic   aw_done, w_done, aw_done_nxt, w_done_nxt;
   logic   tmo_hit;

   logic cmd_ready_q, rsp_valid_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic cmd_ready_d, rsp_valid_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

   logic [pADDR_WIDTH-1:0] addr_q;
   logic [pDATA_WIDTH-1:0] wdata_q;
   logic [pSTRB_WIDTH-1:0] wstrb_q;
   logic [pDATA_WIDTH-1:0] rsp_rdata_q;
   logic [1:0]             rsp_resp_q;

   logic cmd_hs, rsp_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
   assign cmd_hs = cmd_ready_q && bus.cmd_valid;
   assign rsp_hs = rsp_valid_q && bus.rsp_ready;
   assign aw_hs  = awvalid_q   && bus.awready;
   assign w_hs   = wvalid_q    && bus.wready;
   assign b_hs   = bready_q    && bus.bvalid;
   assign ar_hs  = arvalid_q   && bus.arready;
   assign r_hs   = rready_q    && bus.rvalid;

`ifdef AXIL_MSTR_TIMEOUT_EN
   logic wr_q;
   logic timed_out;
   logic wait_rsp;
   assign wait_rsp = (state == WR_RSP) || (state == RD_RSP);

   axil_mstr_tmo #(.pTIMEOUT(pTIMEOUT)) u_tmo (
      .clk    (ALCLK),
      .rst    (ARESET),
      .clr    (!wait_rsp),
      .en     (wait_rsp),
      .expire (tmo_hit)
   );
`else
   assign tmo_hit = 1'b0;
`endif

   // State register plus the registered copies of every handshake output.
   always_ff @(posedge ALCLK) begin
      if (ARESET) begin
         state       <= IDLE;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
      end else begin
         state       <= state_nxt;
         aw_done     <= aw_done_nxt;
         w_done      <= w_done_nxt;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
      end
   end

   // Next state; a real B/R handshake always wins over a same-cycle timeout.
   always_comb begin
      state_nxt   = state;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      case (state)
         IDLE: begin
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            if (cmd_hs) state_nxt = bus.cmd_write ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            aw_done_nxt = aw_done || aw_hs;
            w_done_nxt  = w_done  || w_hs;
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               state_nxt   = WR_RSP;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
            end
         end
         WR_RSP: if (b_hs || tmo_hit) state_nxt = RESP;
         RD_REQ: if (ar_hs) state_nxt = RD_RSP;
         RD_RSP: if (r_hs || tmo_hit) state_nxt = RESP;
         RESP: begin
            if (rsp_hs) begin
`ifdef AXIL_MSTR_TIMEOUT_EN
               state_nxt = timed_out ? DRAIN : IDLE;
`else
               state_nxt = IDLE;
`endif
            end
         end
`ifdef AXIL_MSTR_TIMEOUT_EN
         // The late B or R is taken and thrown away.
         DRAIN: if (wr_q ? b_hs : r_hs) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from the next state so they can be registered without a cycle of lag.
   always_comb begin
      cmd_ready_d = (state_nxt == IDLE);
      rsp_valid_d = (state_nxt == RESP);
      awvalid_d   = (state_nxt == WR_REQ) && !aw_done_nxt;
      wvalid_d    = (state_nxt == WR_REQ) && !w_done_nxt;
      arvalid_d   = (state_nxt == RD_REQ);
`ifdef AXIL_MSTR_TIMEOUT_EN
      bready_d    = (state_nxt == WR_RSP) || ((state_nxt == DRAIN) &&  wr_q);
      rready_d    = (state_nxt == RD_RSP) || ((state_nxt == DRAIN) && !wr_q);
`else
      bready_d    = (state_nxt == WR_RSP);
      rready_d    = (state_nxt == RD_RSP);
`endif
   end

   // Command capture and response payload.
   always_ff @(posedge ALCLK) begin
      if (ARESET) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= OKAY;
`ifdef AXIL_MSTR_TIMEOUT_EN
         wr_q        <= 1'b0;
         timed_out   <= 1'b0;
`endif
      end else begin
         if (cmd_hs) begin
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            wstrb_q <= bus.cmd_wstrb;
`ifdef AXIL_MSTR_TIMEOUT_EN
            wr_q      <= bus.cmd_write;
            timed_out <= 1'b0;
`endif
         end
         if (state == WR_RSP && b_hs) begin
            rsp_rdata_q <= '0;
            rsp_resp_q  <= bus.bresp;
         end else if (state == RD_RSP && r_hs) begin
            rsp_rdata_q <= bus.rdata;
            rsp_resp_q  <= bus.rresp;
         end else if (tmo_hit) begin
            rsp_rdata_q <= '0;
            rsp_resp_q  <= SLVERR;
`ifdef AXIL_MSTR_TIMEOUT_EN
            timed_out   <= 1'b1;
`endif
         end
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_resp  = rsp_resp_q;
   assign bus.awaddr    = addr_q;
   assign bus.awvalid   = awvalid_q;
   assign bus.wdata     = wdata_q;
   assign bus.wstrb     = wstrb_q;
   assign bus.wvalid    = wvalid_q;
   assign bus.bready    = bready_q;
   assign bus.araddr    = addr_q;
   assign bus.arvalid   = arvalid_q;
   assign bus.rready    = rready_q;

endmodule

// File: doc/axil_mstr.md
# axil_mstr

AXI4-Lite initiator that converts a single-outstanding command/response interface into AXI4-Lite read and write transactions. It sits on the initiator side of the AXI-Lite fabric and drives the responder port of the user-project AXI-Lite fan-out block. It is used by the configuration sequencer and test harness to reach user-project registers. Exactly one transaction is in flight at any time.

## Interface
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, AXI-Lite data width; wstrb width is pDATA_WIDTH/8
- pTIMEOUT, 256, response-wait limit in cycles (timeout feature only); must be ≥ 2

- ALCLK  in  1  clock; all logic on rising edge
- ARESET  in  1  reset; synchronous, active-high
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  pADDR_WIDTH  target address
- cmd_wdata  in  pDATA_WIDTH  write data
- cmd_wstrb  in  pDATA_WIDTH/8  write byte strobes
- rsp_valid / rsp_ready  out/in  1  response handshake
- rsp_rdata  out  pDATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- awaddr, awvalid / awready  out, out / in  pADDR_WIDTH, 1 / 1  AW channel
- wdata, wstrb, wvalid / wready  out / in  pDATA_WIDTH, pDATA_WIDTH/8, 1 / 1  W channel
- bresp, bvalid / bready  in / out  2, 1 / 1  B channel
- araddr, arvalid / arready  out, out / in  pADDR_WIDTH, 1 / 1  AR channel
- rdata, rresp, rvalid / rready  in / out  pDATA_WIDTH, 2, 1 / 1  R channel

## Operation
- States: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RESP, DRAIN.
- IDLE: cmd_ready = 1. On a command handshake, capture addr, wdata, and wstrb. Go to WR_REQ or RD_REQ according to cmd_write.
- WR_REQ: awvalid and wvalid are asserted together and are independent. aw_done and w_done flags are set on the respective handshakes. Each valid deasserts on the cycle after its own handshake. Go to WR_RSP once both flags are set, including the case where both complete in the same cycle.
- WR_RSP: bready = 1. On B handshake, latch bresp into rsp_resp, set rsp_rdata = 0, go to RESP.
- RD_REQ: arvalid = 1 until the AR handshake, then go to RD_RSP.
- RD_RSP: rready = 1. On R handshake, latch rdata and rresp, go to RESP.
- RESP: rsp_valid = 1. rsp_rdata and rsp_resp are held stable until rsp_ready. On rsp_ready, go to IDLE.
- A valid, once raised, is never withdrawn before its ready. Address, data, and strobe outputs stay stable while their valid is high.
- DRAIN: reachable only through timeout; see Configuration.
- Reset (any cycle, including mid-transaction): go to IDLE and clear all flags. Every output resets to 0 except cmd_ready, which is 1 in the first cycle after reset.

## Timing
- All outputs are registered.
- Command accepted at cycle 0 → address/data valids high in cycle 1.
- Best-case write, with zero-wait ready and B returned the cycle after the AW/W handshake: rsp_valid in cycle 3.
- Best-case read: AR handshake in cycle 1, R in cycle 2, rsp_valid in cycle 3.
- Back-to-back throughput: one command every 4 cycles minimum.
- cmd_ready is 0 from the cycle after acceptance until the cycle after rsp_valid&&rsp_ready.

## Configuration
- AXIL_MSTR_TIMEOUT_EN defined:
  - A counter runs in WR_RSP and RD_RSP and clears on state entry.
  - If it reaches pTIMEOUT-1 with no B/R handshake, the block reports rsp_resp = 2'b10 and rsp_rdata = 0, and goes to RESP.
  - After rsp_ready, go to DRAIN instead of IDLE. In DRAIN, bready/rready stays high and the block waits for the late B/R. That B/R is discarded, then the block returns to IDLE.
  - Address phases never time out.
- Macro undefined: no counter and no DRAIN state; the block waits for B/R indefinitely.

## Structure
- Package axil_pkg holds:
  - the state enum;
  - localparams for OKAY = 2'b00 and SLVERR = 2'b10;
  - the strobe-width helper.
- Sub-module axil_mstr_tmo contains the timeout counter (load/clear/expire). It is instantiated only under AXIL_MSTR_TIMEOUT_EN.

## Test plan
- Write 0x010, data 0xDEADBEEF, strobe 0xF, zero-wait responder, bresp = 0 → AW/W fire together in cycle 1, rsp_valid in cycle 3, rsp_resp = 0, rsp_rdata = 0.
- Write where wready lags awready by 3 cycles → awvalid drops after its handshake, wvalid holds with stable wdata, bready is asserted only after both handshakes.
- Read 0x020, responder returns 0x12345678 with rresp = 2'b10 after 5 wait cycles → rsp_rdata = 0x12345678, rsp_resp = 2'b10.
- rsp_ready held low for 10 cycles → rsp_valid and payload stable and cmd_ready = 0 throughout; a second command is accepted only after the response handshake.
- ARESET asserted during WR_RSP → next cycle all valids/readies are 0 and cmd_ready = 1; a subsequent read completes normally.
- With AXIL_MSTR_TIMEOUT_EN and pTIMEOUT = 16, B never returned → rsp_resp = 2'b10 sixteen cycles after entering WR_RSP. A late bvalid in DRAIN is absorbed, and the block then returns to IDLE.
